// File: rtl/st_dispatch_pkg.sv
// Shared types and constants for the store dispatch block: size and drain-state
// enums, region decode constants and output-peripheral bank word indices.
package st_dispatch_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } st_size_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_GAP  = 2'b10
    } drain_state_e;

    // Region match is (addr[15:0] & MASK) == BASE
    localparam logic [15:0] OP_BASE   = 16'h7000;
    localparam logic [15:0] OP_MASK   = 16'hFFC0;
    localparam logic [15:0] SRAM_BASE = 16'h2000;
    localparam logic [15:0] SRAM_MASK = 16'hE000;

    localparam int BANK_WORDS  = 16;
    localparam int BANK_LEDR   = 0;
    localparam int BANK_LEDG   = 4;
    localparam int BANK_HEX_LO = 8;
    localparam int BANK_HEX_HI = 9;
    localparam int BANK_LCD    = 12;

endpackage

// File: rtl/st_dispatch_wbuf.sv
// Small synchronous FIFO holding pending SRAM writes; head entry is visible
// combinationally so the drain side can present it while waiting for ack.
module st_wbuf #(
    parameter int WIDTH = 47,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push_ok;
    logic             pop_ok;

    assign o_full  = (count_q == CW'(DEPTH));
    assign o_empty = (count_q == '0);
    assign o_count = count_q;
    assign o_data  = mem_q[rd_ptr_q];

    assign push_ok = i_push & ~o_full;
    assign pop_ok  = i_pop & ~o_empty;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is not reset; stale entries are never visible because the
    // pointers and count are.
    always_ff @(posedge i_clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= i_data;
    end

endmodule

// File: rtl/st_dispatch.sv
// Store dispatch: decodes each store, writes output-peripheral stores into a
// 16-word bank and queues SRAM stores for a req/ack drain. Option: ST_ERR_STICKY_EN.
module st_dispatch
    import st_dispatch_pkg::*;
#(
    parameter int WBUF_DEPTH = 4,
    parameter int SRAM_AW    = 11
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_st_en,
    input  logic [31:0]        i_addr,
    input  logic [31:0]        i_st_data,
    input  logic [1:0]         i_st_size,
    output logic               o_st_ready,
    output logic [31:0]        o_op_rdata,
    output logic [31:0]        o_io_ledr,
    output logic [31:0]        o_io_ledg,
    output logic [31:0]        o_io_hex_lo,
    output logic [31:0]        o_io_hex_hi,
    output logic [31:0]        o_io_lcd,
    output logic               o_sram_req,
    output logic [SRAM_AW-1:0] o_sram_addr,
    output logic [31:0]        o_sram_wdata,
    output logic [3:0]         o_sram_be,
    input  logic               i_sram_ack,
    output logic               o_wbuf_empty,
    output logic               o_st_err
);

    localparam int EW = SRAM_AW + 36;

    logic [15:0]                 addr_lo;
    logic                        op_hit;
    logic                        sram_hit;
    logic                        legal;
    logic [3:0]                  be;
    logic [31:0]                 lane_data;
    logic                        st_accept;
    logic                        op_wr;
    logic                        sram_push;
    logic                        st_drop;
    logic                        wbuf_pop;
    logic                        wbuf_full;
    logic                        wbuf_empty;
    logic [$clog2(WBUF_DEPTH):0] wbuf_count;
    logic [EW-1:0]               wbuf_head;
    logic [32*BANK_WORDS-1:0]    bank_flat;
    drain_state_e                state_q;
    logic                        req_q;
    logic                        err_q;
    logic                        unused_bits;

    assign addr_lo  = i_addr[15:0];
    assign op_hit   = (addr_lo & OP_MASK) == OP_BASE;
    assign sram_hit = (addr_lo & SRAM_MASK) == SRAM_BASE;

    always_comb begin
        be        = 4'b0000;
        lane_data = i_st_data;
        legal     = 1'b0;
        case (st_size_e'(i_st_size))
            SZ_BYTE: begin
                be        = 4'b0001 << i_addr[1:0];
                lane_data = {4{i_st_data[7:0]}};
                legal     = 1'b1;
            end
            SZ_HALF: begin
                be        = i_addr[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{i_st_data[15:0]}};
                legal     = ~i_addr[0];
            end
            SZ_WORD: begin
                be        = 4'b1111;
                legal     = (i_addr[1:0] == 2'b00);
            end
            default: ;
        endcase
    end

    assign st_accept = i_st_en & o_st_ready;
    assign op_wr     = st_accept & legal & op_hit;
    assign sram_push = st_accept & legal & sram_hit;
    assign st_drop   = st_accept & ~(legal & (op_hit | sram_hit));

    // Ready looks only at occupancy; a same-cycle pop does not free a slot early.
    assign o_st_ready   = ~wbuf_full;
    assign o_wbuf_empty = wbuf_empty;

    st_wbuf #(
        .WIDTH (EW),
        .DEPTH (WBUF_DEPTH)
    ) u_wbuf (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (sram_push),
        .i_data  ({i_addr[SRAM_AW+1:2], lane_data, be}),
        .i_pop   (wbuf_pop),
        .o_data  (wbuf_head),
        .o_full  (wbuf_full),
        .o_empty (wbuf_empty),
        .o_count (wbuf_count)
    );

    generate
        for (genvar gi = 0; gi < BANK_WORDS; gi++) begin : g_bank
            logic [31:0] word_q;
            logic        wr_en;

            assign wr_en = op_wr & (i_addr[5:2] == 4'(gi));

            always_ff @(posedge i_clk) begin
                if (i_reset) begin
                    word_q <= '0;
                end else if (wr_en) begin
                    for (int b = 0; b < 4; b++) begin
                        if (be[b]) word_q[8*b +: 8] <= lane_data[8*b +: 8];
                    end
                end
            end

            assign bank_flat[32*gi +: 32] = word_q;
        end
    endgenerate

    assign o_op_rdata  = bank_flat[{i_addr[5:2], 5'b00000} +: 32];
    assign o_io_ledr   = bank_flat[32*BANK_LEDR   +: 32];
    assign o_io_ledg   = bank_flat[32*BANK_LEDG   +: 32];
    assign o_io_hex_lo = bank_flat[32*BANK_HEX_LO +: 32];
    assign o_io_hex_hi = bank_flat[32*BANK_HEX_HI +: 32];
    assign o_io_lcd    = bank_flat[32*BANK_LCD    +: 32];

    // Drain FSM: GAP enforces a turnaround cycle between consecutive requests.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!wbuf_empty) begin
                        state_q <= S_REQ;
                        req_q   <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (i_sram_ack) begin
                        state_q <= S_GAP;
                        req_q   <= 1'b0;
                    end
                end
                S_GAP: state_q <= S_IDLE;
                default: begin
                    state_q <= S_IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign wbuf_pop     = (state_q == S_REQ) & i_sram_ack;
    assign o_sram_req   = req_q;
    assign o_sram_addr  = req_q ? wbuf_head[EW-1 -: SRAM_AW] : '0;
    assign o_sram_wdata = req_q ? wbuf_head[35:4] : '0;
    assign o_sram_be    = req_q ? wbuf_head[3:0] : '0;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            err_q <= 1'b0;
`ifdef ST_ERR_STICKY_EN
        end else if (st_drop) begin
            err_q <= 1'b1;
`else
        end else begin
            err_q <= st_drop;
`endif
        end
    end

    assign o_st_err = err_q;

    assign unused_bits = ^{i_addr[31:16], wbuf_count};

endmodule

// File: tb/tb_st_dispatch.sv
// Randomized self-checking bench for st_dispatch against a byte-level
// reference model of the register bank, write queue and request timing.
module tb_st_dispatch;

    localparam int DEPTH = 4;
    localparam int AW    = 11;

    typedef struct packed {
        logic [10:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } entry_t;

    logic          i_clk = 1'b0;
    logic          i_reset;
    logic          i_st_en;
    logic [31:0]   i_addr;
    logic [31:0]   i_st_data;
    logic [1:0]    i_st_size;
    logic          o_st_ready;
    logic [31:0]   o_op_rdata;
    logic [31:0]   o_io_ledr;
    logic [31:0]   o_io_ledg;
    logic [31:0]   o_io_hex_lo;
    logic [31:0]   o_io_hex_hi;
    logic [31:0]   o_io_lcd;
    logic          o_sram_req;
    logic [AW-1:0] o_sram_addr;
    logic [31:0]   o_sram_wdata;
    logic [3:0]    o_sram_be;
    logic          i_sram_ack;
    logic          o_wbuf_empty;
    logic          o_st_err;

    always #5 i_clk = ~i_clk;

    st_dispatch #(.WBUF_DEPTH(DEPTH), .SRAM_AW(AW)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_st_en      (i_st_en),
        .i_addr       (i_addr),
        .i_st_data    (i_st_data),
        .i_st_size    (i_st_size),
        .o_st_ready   (o_st_ready),
        .o_op_rdata   (o_op_rdata),
        .o_io_ledr    (o_io_ledr),
        .o_io_ledg    (o_io_ledg),
        .o_io_hex_lo  (o_io_hex_lo),
        .o_io_hex_hi  (o_io_hex_hi),
        .o_io_lcd     (o_io_lcd),
        .o_sram_req   (o_sram_req),
        .o_sram_addr  (o_sram_addr),
        .o_sram_wdata (o_sram_wdata),
        .o_sram_be    (o_sram_be),
        .i_sram_ack   (i_sram_ack),
        .o_wbuf_empty (o_wbuf_empty),
        .o_st_err     (o_st_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] bank_m [16];
    entry_t      q_m [$];
    bit          req_m;
    int          since_ack_m;
    bit          err_m;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: bank as bytes, queue as a list, request timing from the
    // "one req until ack, then at least two idle cycles" rule.
    function automatic void model_update(bit en, logic [31:0] a, logic [31:0] d,
                                         logic [1:0] sz, bit ack, bit rst);
        int lo, n, off, idx;
        bit acc, op, sram, legal, pop, nreq, drop;
        entry_t e;
        if (rst) begin
            foreach (bank_m[k]) bank_m[k] = '0;
            q_m.delete();
            req_m       = 1'b0;
            since_ack_m = 2;
            err_m       = 1'b0;
            return;
        end
        lo    = int'(a[15:0]);
        n     = 1 << sz;
        off   = lo % 4;
        idx   = (lo >> 2) & 15;
        op    = (lo >= 'h7000) && (lo <= 'h703F);
        sram  = (lo >= 'h2000) && (lo <= 'h3FFF);
        legal = (sz != 2'd3) && (lo % n == 0);
        acc   = en && (q_m.size() < DEPTH);
        pop   = req_m && ack;
        nreq  = req_m ? !ack : ((q_m.size() > 0) && (since_ack_m >= 2));
        since_ack_m = pop ? 1 : ((since_ack_m < 2) ? since_ack_m + 1 : 2);
        drop  = acc && !(legal && (op || sram));
`ifdef ST_ERR_STICKY_EN
        err_m = err_m | drop;
`else
        err_m = drop;
`endif
        if (pop) void'(q_m.pop_front());
        if (acc && legal && op) begin
            for (int k = 0; k < n; k++) bank_m[idx][8*(off+k) +: 8] = d[8*k +: 8];
        end
        if (acc && legal && sram) begin
            e.a  = a[12:2];
            e.be = 4'b0000;
            for (int j = 0; j < 4; j++) begin
                e.d[8*j +: 8] = d[8*(j % n) +: 8];
                if (j >= off && j < off + n) e.be[j] = 1'b1;
            end
            q_m.push_back(e);
        end
        req_m = nreq;
    endfunction

    task automatic compare_all();
        check("ready", o_st_ready, q_m.size() < DEPTH);
        check("empty", o_wbuf_empty, q_m.size() == 0);
        check("req", o_sram_req, req_m);
        if (req_m && q_m.size() > 0) begin
            check("sram_addr", o_sram_addr, q_m[0].a);
            check("sram_wdata", o_sram_wdata, q_m[0].d);
            check("sram_be", o_sram_be, q_m[0].be);
        end
        check("err", o_st_err, err_m);
        check("rdata", o_op_rdata, bank_m[i_addr[5:2]]);
        check("ledr", o_io_ledr, bank_m[0]);
        check("ledg", o_io_ledg, bank_m[4]);
        check("hex_lo", o_io_hex_lo, bank_m[8]);
        check("hex_hi", o_io_hex_hi, bank_m[9]);
        check("lcd", o_io_lcd, bank_m[12]);
    endtask

    // One clock: drive at negedge, compare current state, then advance the model.
    task automatic step(input bit en, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] sz, input bit ack, input bit rst);
        i_st_en    = en;
        i_addr     = a;
        i_st_data  = d;
        i_st_size  = sz;
        i_sram_ack = ack;
        i_reset    = rst;
        #1;
        compare_all();
        @(posedge i_clk);
        model_update(en, a, d, sz, ack, rst);
        @(negedge i_clk);
    endtask

    task automatic idle(input bit ack);
        step(1'b0, 32'h0000_7000, 32'h0, 2'd0, ack, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic [1:0]  sz;
        bit          done;

        i_reset = 1'b1; i_st_en = 1'b0; i_addr = '0; i_st_data = '0;
        i_st_size = '0; i_sram_ack = 1'b0;
        @(posedge i_clk);
        model_update(1'b0, '0, '0, '0, 1'b0, 1'b1);
        @(negedge i_clk);
        step(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b1);
        check("rst_ready", o_st_ready, 1'b1);
        check("rst_empty", o_wbuf_empty, 1'b1);
        check("rst_req", o_sram_req, 1'b0);

        // Word then byte into LEDR
        step(1'b1, 32'h0000_7000, 32'hDEAD_BEEF, 2'd2, 1'b0, 1'b0);
        check("ledr_word", o_io_ledr, 32'hDEAD_BEEF);
        step(1'b1, 32'h0000_7001, 32'h0000_0055, 2'd0, 1'b0, 1'b0);
        check("ledr_byte", o_io_ledr, 32'hDEAD_55EF);
        idle(1'b0);

        // Half store to SRAM with ack tied high
        step(1'b1, 32'h0000_2006, 32'h0000_1234, 2'd1, 1'b1, 1'b0);
        check("half_idle_req", o_sram_req, 1'b0);
        idle(1'b1);
        check("half_req", o_sram_req, 1'b1);
        check("half_addr", o_sram_addr, 11'h001);
        check("half_be", o_sram_be, 4'b1100);
        check("half_wdata", o_sram_wdata, 32'h1234_1234);
        idle(1'b1);
        check("half_gap_req", o_sram_req, 1'b0);
        check("half_empty", o_wbuf_empty, 1'b1);
        idle(1'b1);

        // Fill the buffer, hold the fifth store until a slot frees
        for (int k = 0; k < 4; k++)
            step(1'b1, 32'h0000_2000 + 32'(4*k), 32'hA000_0000 + 32'(k), 2'd2, 1'b0, 1'b0);
        check("full_ready", o_st_ready, 1'b0);
        done = 1'b0;
        for (int g = 0; g < 8 && !done; g++) begin
            done = (q_m.size() < DEPTH);
            step(1'b1, 32'h0000_2010, 32'hA000_0004, 2'd2, 1'b1, 1'b0);
        end
        if (!done) check("hold_timeout", 1'b0, 1'b1);
        for (int k = 0; k < 20; k++) idle(1'b1);

        // Misaligned word and input-peripheral byte are both dropped
        step(1'b1, 32'h0000_2002, 32'h1111_1111, 2'd2, 1'b0, 1'b0);
        check("err_misalign", o_st_err, 1'b1);
        step(1'b1, 32'h0000_7804, 32'h0000_00AA, 2'd0, 1'b0, 1'b0);
        check("err_unmapped", o_st_err, 1'b1);
        check("err_no_push", o_wbuf_empty, 1'b1);
        idle(1'b0);

        // Reset in the middle of a request with three queued entries
        step(1'b1, 32'h0000_7030, 32'hCAFE_F00D, 2'd2, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++)
            step(1'b1, 32'h0000_3000 + 32'(4*k), 32'hB000_0000 + 32'(k), 2'd2, 1'b0, 1'b0);
        check("pre_rst_req", o_sram_req, 1'b1);
        step(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b1);
        check("mid_rst_req", o_sram_req, 1'b0);
        check("mid_rst_empty", o_wbuf_empty, 1'b1);
        check("mid_rst_ready", o_st_ready, 1'b1);
        check("mid_rst_ledr", o_io_ledr, 32'h0);
        check("mid_rst_lcd", o_io_lcd, 32'h0);
        check("mid_rst_err", o_st_err, 1'b0);
        idle(1'b0);

        // Push and pop in the same cycle at count 2
        step(1'b1, 32'h0000_2100, 32'hC000_0000, 2'd2, 1'b0, 1'b0);
        step(1'b1, 32'h0000_2104, 32'hC000_0001, 2'd2, 1'b0, 1'b0);
        for (int g = 0; g < 4 && !req_m; g++) idle(1'b0);
        check("pp_req", o_sram_req, 1'b1);
        step(1'b1, 32'h0000_2108, 32'hC000_0002, 2'd2, 1'b1, 1'b0);
        check("pp_gap", o_sram_req, 1'b0);
        idle(1'b0);
        idle(1'b0);
        check("pp_next_addr", o_sram_addr, 11'h041);
        for (int k = 0; k < 12; k++) idle(1'b1);

        // Randomized mix of regions, sizes, alignments and ack patterns
        for (int t = 0; t < 600; t++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0: a[15:0] = 16'h7000 | 16'($urandom_range(0, 63));
                1: a[15:0] = 16'h2000 + 16'($urandom_range(0, 8191));
                2: a[15:0] = 16'h7800 | 16'($urandom_range(0, 63));
                default: ;
            endcase
            sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            d = $urandom;
            step(1'($urandom_range(0, 1)), a, d, sz, 1'($urandom_range(0, 1)), 1'b0);
        end
        for (int k = 0; k < 30; k++) idle(1'b1);
        check("final_empty", o_wbuf_empty, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
